// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 memory-port arbiter: default widths,
// controller state encodings and requester index constants.
package cvp14_pkg;

  // Default datapath geometry of the system memory port
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_RD_LAT = 1;

  // Burst controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Requester slots: bit positions in Req/Gnt/WAck/RValid/Done
  localparam int REQ_CORE = 0;
  localparam int REQ_DMA  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin selector. The priority pointer names the requester
// that wins a tie; it flips each time the owner strobes advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] win
);

  logic ptr;

  // Priority pointer: starts at requester 0 and flips once per completed burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  // One-hot winner: a lone request always wins, a tie goes to the pointer
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single system-memory port between the CVP14 core load/store
// path (requester 0) and the DMA/host loader (requester 1). Bursts are
// granted round-robin and always run to completion, so a vector burst is
// never split. Memory strobes, address and write data are decoded from the
// registered burst state; read data returns through a short latency pipe.
module mem_port_arbiter
  import cvp14_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic [1:0]        Req,
  input  logic [1:0]        ReqWr,
  input  logic [ADDR_W-1:0] ReqAddr0,
  input  logic [ADDR_W-1:0] ReqAddr1,
  input  logic [LEN_W-1:0]  ReqLen0,
  input  logic [LEN_W-1:0]  ReqLen1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic [1:0]        Gnt,
  output logic [1:0]        WAck,
  output logic [1:0]        RValid,
  output logic [DATA_W-1:0] RData,
  output logic [1:0]        Done,
  output logic [ADDR_W-1:0] Addr,
  output logic              RD,
  output logic              WR,
  output logic [DATA_W-1:0] DataOut,
  input  logic [DATA_W-1:0] DataIn
);

  localparam logic [LEN_W-1:0]  LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  logic [1:0]        state;
  logic [1:0]        win;
  logic              advance;
  logic [ADDR_W-1:0] addr_cnt;
  logic [LEN_W-1:0]  word_cnt;
  logic [LEN_W-1:0]  last_idx;
  logic              wr_burst;
  logic [1:0]        drain_cnt;
  logic              in_xfer;
  logic              dma_owns;
  logic [RD_LAT-1:0] rd_pipe;
  logic [RD_LAT:0]   rd_taps;

  // The pointer moves on the FIN cycle, i.e. only for bursts that finish
  assign advance = (state == ST_FIN);

  rr_arb2 u_arb (
    .clk     (Clk1),
    .rst     (Reset),
    .req     (Req),
    .advance (advance),
    .win     (win)
  );

  // Burst sequencer: latches the winner's request in IDLE, walks the words,
  // waits out the read latency, then pulses Done and releases the grant.
  // A zero length field wraps to all-ones as the last index, giving 16 words.
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      Gnt       <= 2'b00;
      Done      <= 2'b00;
      addr_cnt  <= '0;
      word_cnt  <= '0;
      last_idx  <= '0;
      wr_burst  <= 1'b0;
      drain_cnt <= 2'd0;
    end else begin
      Done <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (win != 2'b00) begin
            Gnt      <= win;
            addr_cnt <= win[REQ_DMA] ? ReqAddr1 : ReqAddr0;
            last_idx <= (win[REQ_DMA] ? ReqLen1 : ReqLen0) - LEN_ONE;
            wr_burst <= win[REQ_DMA] ? ReqWr[REQ_DMA] : ReqWr[REQ_CORE];
            word_cnt <= '0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          addr_cnt <= addr_cnt + ADDR_ONE;
          word_cnt <= word_cnt + LEN_ONE;
          if (word_cnt == last_idx) begin
            drain_cnt <= 2'd0;
            state     <= wr_burst ? ST_FIN : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= ST_FIN;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        ST_FIN: begin
          Done  <= Gnt;
          Gnt   <= 2'b00;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory-side decode: the port is only driven while words are issued, so
  // a reset drops the strobes immediately without waiting for a clock edge
  assign in_xfer  = (state == ST_XFER);
  assign dma_owns = Gnt[REQ_DMA];
  assign Addr     = in_xfer ? addr_cnt : '0;
  assign WR       = in_xfer & wr_burst;
  assign RD       = in_xfer & ~wr_burst;
  assign DataOut  = WR ? (dma_owns ? WData1 : WData0) : '0;
  assign WAck     = WR ? Gnt : 2'b00;

  // Tap 0 is the live RD strobe, tap i is RD delayed by i cycles. DataIn is
  // captured at the end of the cycle in which tap RD_LAT-1 is set, so RValid
  // (tap RD_LAT) lands exactly RD_LAT cycles after the matching RD cycle.
  assign rd_taps = {rd_pipe, RD};
  assign RValid  = rd_taps[RD_LAT] ? Gnt : 2'b00;

  // Read-latency shift register and the returned-data holding register
  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      rd_pipe <= '0;
      RData   <= '0;
    end else begin
      rd_pipe <= rd_taps[RD_LAT-1:0];
      if (rd_taps[RD_LAT-1]) begin
        RData <= DataIn;
      end
    end
  end

  // Structural invariants of the port
  a_gnt_onehot: assert property (@(posedge Clk1) disable iff (Reset) Gnt != 2'b11);
  a_rd_wr_excl: assert property (@(posedge Clk1) disable iff (Reset) !(RD && WR));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level model turns
// each granted request into the list of per-cycle port values the burst must
// produce; one process compares every cycle. Directed tests add literal
// expectations (latency, address wrap, grant order) that pin the model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  localparam int RD_LAT = 1;

  logic              Clk1 = 1'b0;
  logic              Reset = 1'b1;
  logic [1:0]        Req = 2'b00;
  logic [1:0]        ReqWr = 2'b00;
  logic [ADDR_W-1:0] ReqAddr0 = '0;
  logic [ADDR_W-1:0] ReqAddr1 = '0;
  logic [LEN_W-1:0]  ReqLen0 = '0;
  logic [LEN_W-1:0]  ReqLen1 = '0;
  logic [DATA_W-1:0] WData0 = '0;
  logic [DATA_W-1:0] WData1 = '0;
  logic [1:0]        Gnt;
  logic [1:0]        WAck;
  logic [1:0]        RValid;
  logic [DATA_W-1:0] RData;
  logic [1:0]        Done;
  logic [ADDR_W-1:0] Addr;
  logic              RD;
  logic              WR;
  logic [DATA_W-1:0] DataOut;
  logic [DATA_W-1:0] DataIn;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clk1     (Clk1),
    .Reset    (Reset),
    .Req      (Req),
    .ReqWr    (ReqWr),
    .ReqAddr0 (ReqAddr0),
    .ReqAddr1 (ReqAddr1),
    .ReqLen0  (ReqLen0),
    .ReqLen1  (ReqLen1),
    .WData0   (WData0),
    .WData1   (WData1),
    .Gnt      (Gnt),
    .WAck     (WAck),
    .RValid   (RValid),
    .RData    (RData),
    .Done     (Done),
    .Addr     (Addr),
    .RD       (RD),
    .WR       (WR),
    .DataOut  (DataOut),
    .DataIn   (DataIn)
  );

  // Memory model: every location reads back its own address
  assign DataIn = Addr;

  always #5 Clk1 = ~Clk1;

  int vecs = 0;
  int miss = 0;

  logic [DATA_W-1:0] wbase [2];

  typedef struct {
    logic [1:0]        gnt;
    logic [1:0]        wack;
    logic [1:0]        rvalid;
    logic [1:0]        done;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataout;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t expq [$];
  int   mptr = 0;

  // Observations collected by runBursts for the directed literal checks
  int                order [$];
  logic [ADDR_W-1:0] wrAddrs [$];
  int rdCount, rvCount, wackCount, xferCount, latency, doneSeen;
  logic [DATA_W-1:0] firstRData;
  logic [ADDR_W-1:0] firstAddr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idleRec();
    exp_t e;
    e.gnt = 2'b00; e.wack = 2'b00; e.rvalid = 2'b00; e.done = 2'b00;
    e.rd = 1'b0; e.wr = 1'b0; e.addr = '0; e.dataout = '0; e.rdata = '0;
    return e;
  endfunction

  // Expand one granted burst into its per-cycle port values: N word cycles,
  // RD_LAT extra cycles for reads, one closing cycle, then the Done cycle
  task automatic buildBurst();
    int w, n, total, rw;
    logic wr;
    logic [ADDR_W-1:0] base;
    logic [1:0] g;
    exp_t e;
    w    = (Req == 2'b11) ? mptr : (Req[1] ? 1 : 0);
    g    = (w == 1) ? 2'b10 : 2'b01;
    base = (w == 1) ? ReqAddr1 : ReqAddr0;
    n    = (w == 1) ? int'(ReqLen1) : int'(ReqLen0);
    if (n == 0) n = 16;
    wr    = ReqWr[w];
    total = n + (wr ? 0 : RD_LAT) + 2;
    for (int j = 0; j < total; j++) begin
      e = idleRec();
      if (j < total - 1) e.gnt = g;
      else               e.done = g;
      if (j < n) begin
        e.addr = base + ADDR_W'(j);
        e.rd   = ~wr;
        e.wr   = wr;
        if (wr) begin
          e.wack    = g;
          e.dataout = wbase[w] + DATA_W'(j);
        end
      end
      rw = j - RD_LAT;
      if (!wr && rw >= 0 && rw < n) begin
        e.rvalid = g;
        e.rdata  = base + ADDR_W'(rw);
      end
      expq.push_back(e);
    end
  endtask

  // Model and compare process: decide grants at the clock edge, check the
  // port on the opposite edge
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk1);
      if (Reset) begin
        expq.delete();
        mptr = 0;
      end else if (expq.size() == 0 && Req != 2'b00) begin
        buildBurst();
      end
      @(negedge Clk1);
      if (!Reset) begin
        if (expq.size() > 0) e = expq.pop_front();
        else                 e = idleRec();
        if (e.done != 2'b00) mptr = 1 - mptr;
        checkOutput("gnt", 32'(Gnt), 32'(e.gnt));
        checkOutput("wack", 32'(WAck), 32'(e.wack));
        checkOutput("rvalid", 32'(RValid), 32'(e.rvalid));
        checkOutput("done", 32'(Done), 32'(e.done));
        checkOutput("rd", 32'(RD), 32'(e.rd));
        checkOutput("wr", 32'(WR), 32'(e.wr));
        if (e.rd || e.wr) checkOutput("addr", 32'(Addr), 32'(e.addr));
        if (e.wr) checkOutput("dataout", 32'(DataOut), 32'(e.dataout));
        if (e.rvalid != 2'b00) checkOutput("rdata", 32'(RData), 32'(e.rdata));
      end
    end
  end

  // Requester write-data sources: present the next word the cycle after WAck
  initial begin
    logic [1:0] g, w;
    int widx [2];
    widx[0] = 0;
    widx[1] = 0;
    wbase[0] = 16'hC000;
    wbase[1] = 16'hD000;
    forever begin
      @(negedge Clk1);
      g = Gnt;
      w = WAck;
      @(posedge Clk1);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!g[i])     widx[i] = 0;
        else if (w[i]) widx[i] = widx[i] + 1;
      end
      WData0 = wbase[0] + DATA_W'(widx[0]);
      WData1 = wbase[1] + DATA_W'(widx[1]);
    end
  end

  task automatic applyReset();
    @(negedge Clk1);
    #2;
    Reset = 1'b1;
    Req   = 2'b00;
    repeat (2) @(negedge Clk1);
    checkOutput("rst_gnt", 32'(Gnt), 32'h0);
    checkOutput("rst_done", 32'(Done), 32'h0);
    checkOutput("rst_strobes", 32'({RD, WR}), 32'h0);
    checkOutput("rst_rvalid_wack", 32'({RValid, WAck}), 32'h0);
    checkOutput("rst_addr", 32'(Addr), 32'h0);
    checkOutput("rst_dataout", 32'(DataOut), 32'h0);
    checkOutput("rst_rdata", 32'(RData), 32'h0);
    #2;
    Reset = 1'b0;
  endtask

  task automatic applyStimulus(input int who, input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] wb);
    wbase[who] = wb;
    ReqWr[who] = wr;
    if (who == 1) begin
      ReqAddr1 = addr;
      ReqLen1  = len;
    end else begin
      ReqAddr0 = addr;
      ReqLen0  = len;
    end
    Req[who] = 1'b1;
  endtask

  // Run until wantDone bursts have finished, holding each Req until its Done.
  // Once granted, the owner's request fields are scrambled; they must not
  // matter any more. dropAfter > 0 releases Req0 after that many words.
  task automatic runBursts(input int wantDone, input int dropAfter);
    int cyc, gntCyc;
    logic [1:0] prevG;
    cyc = 0; gntCyc = 0; prevG = 2'b00;
    order.delete(); wrAddrs.delete();
    rdCount = 0; rvCount = 0; wackCount = 0; xferCount = 0; latency = -1; doneSeen = 0;
    firstRData = '0; firstAddr = '0;
    while (doneSeen < wantDone && cyc < 400) begin
      @(negedge Clk1);
      cyc++;
      if (Gnt != 2'b00 && prevG == 2'b00) begin
        order.push_back(Gnt[1] ? 1 : 0);
        gntCyc = cyc;
        if (Gnt[1]) begin ReqAddr1 = ~ReqAddr1; ReqLen1 = ReqLen1 + 4'd5; ReqWr[1] = ~ReqWr[1]; end
        else        begin ReqAddr0 = ~ReqAddr0; ReqLen0 = ReqLen0 + 4'd5; ReqWr[0] = ~ReqWr[0]; end
      end
      if (RD && rdCount == 0) firstAddr = Addr;
      if (RD) rdCount++;
      if (RValid != 2'b00) begin
        if (rvCount == 0) firstRData = RData;
        rvCount++;
      end
      if (WAck != 2'b00) wackCount++;
      if (WR) wrAddrs.push_back(Addr);
      if (RD || WR) xferCount++;
      if (dropAfter > 0 && xferCount == dropAfter) Req[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (Done[i]) begin
          Req[i] = 1'b0;
          doneSeen++;
          if (latency < 0) latency = cyc - gntCyc;
        end
      end
      prevG = Gnt;
    end
    if (doneSeen < wantDone) begin
      vecs++;
      miss++;
      $display("[TB] FAIL burst_timeout: got %0d Done pulses, required %0d", doneSeen, wantDone);
    end
    @(negedge Clk1);
  endtask

  initial begin
    int xf;
    $display("[TB] mem_port_arbiter bench start");
    applyReset();

    // Core read, base 0x0100, 4 words
    applyStimulus(0, 1'b0, 16'h0100, 4'd4, 16'hC000);
    runBursts(1, 0);
    checkOutput("t1_latency", 32'(latency), 32'd6);
    checkOutput("t1_rd_count", 32'(rdCount), 32'd4);
    checkOutput("t1_rvalid_count", 32'(rvCount), 32'd4);
    checkOutput("t1_first_addr", 32'(firstAddr), 32'h0100);
    checkOutput("t1_first_rdata", 32'(firstRData), 32'h0100);

    // Simultaneous writes from a fresh pointer alternate 0,1 and again 0,1
    applyReset();
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(0, 1'b1, 16'h0200, 4'd2, 16'hC100);
      applyStimulus(1, 1'b1, 16'h0400, 4'd2, 16'hD100);
      runBursts(2, 0);
      checkOutput("t2_first_winner", 32'(order.size() > 0 ? order[0] : 9), 32'd0);
      checkOutput("t2_second_winner", 32'(order.size() > 1 ? order[1] : 9), 32'd1);
      checkOutput("t2_wack_count", 32'(wackCount), 32'd4);
    end

    // Core write across the top of the address space
    applyStimulus(0, 1'b1, 16'hFFFE, 4'd3, 16'hC200);
    runBursts(1, 0);
    checkOutput("t3_wr_words", 32'(wrAddrs.size()), 32'd3);
    checkOutput("t3_addr0", 32'(wrAddrs.size() > 0 ? wrAddrs[0] : 16'h1234), 32'hFFFE);
    checkOutput("t3_addr1", 32'(wrAddrs.size() > 1 ? wrAddrs[1] : 16'h1234), 32'hFFFF);
    checkOutput("t3_addr2", 32'(wrAddrs.size() > 2 ? wrAddrs[2] : 16'h1234), 32'h0000);
    checkOutput("t3_wack_count", 32'(wackCount), 32'd3);
    checkOutput("t3_latency", 32'(latency), 32'd4);

    // DMA read with length field 0 runs 16 words
    applyStimulus(1, 1'b0, 16'h0800, 4'd0, 16'hD200);
    runBursts(1, 0);
    checkOutput("t4_rd_count", 32'(rdCount), 32'd16);
    checkOutput("t4_rvalid_count", 32'(rvCount), 32'd16);
    checkOutput("t4_latency", 32'(latency), 32'd18);

    // Core read of 8 words with Req0 dropped after word 2
    applyStimulus(0, 1'b0, 16'h0A00, 4'd8, 16'hC300);
    runBursts(1, 3);
    checkOutput("t5_rd_count", 32'(rdCount), 32'd8);
    checkOutput("t5_done_count", 32'(doneSeen), 32'd1);

    // Pointer now favours requester 1; reset at word 5 of a 16-word read
    applyStimulus(0, 1'b0, 16'h0300, 4'd0, 16'hC400);
    xf = 0;
    doneSeen = 0;
    for (int c = 0; c < 40 && xf < 6; c++) begin
      @(negedge Clk1);
      if (RD || WR) xf++;
      if (Done != 2'b00) doneSeen++;
    end
    checkOutput("t6_reached_word5", 32'(xf), 32'd6);
    #2;
    Reset = 1'b1;
    Req   = 2'b00;
    #1;
    checkOutput("t6_async_rd", 32'(RD), 32'h0);
    checkOutput("t6_async_wr", 32'(WR), 32'h0);
    checkOutput("t6_async_gnt", 32'(Gnt), 32'h0);
    repeat (2) @(negedge Clk1);
    #2;
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk1);
      if (Done != 2'b00) doneSeen++;
    end
    checkOutput("t6_idle_gnt", 32'(Gnt), 32'h0);
    checkOutput("t6_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(0, 1'b1, 16'h0500, 4'd1, 16'hC500);
    applyStimulus(1, 1'b1, 16'h0600, 4'd1, 16'hD500);
    runBursts(2, 0);
    checkOutput("t6_ptr_reset_winner", 32'(order.size() > 0 ? order[0] : 9), 32'd0);
    checkOutput("t6_second_winner", 32'(order.size() > 1 ? order[1] : 9), 32'd1);

    repeat (2) @(negedge Clk1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single system-memory port (Addr/RD/WR/DataOut/DataIn) between two burst requesters: requester 0 is the CVP14 core load/store path; requester 1 is the DMA/host loader.
- Arbitration is round-robin at burst granularity. A granted burst runs to completion without interruption, so a 16-word VLD/VST is never split.
- The block generates sequential addresses, drives the memory strobes and returns read data to the granted requester.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- LEN_W, 4, burst length field width; a value of 0 means 2^LEN_W words (16)
- RD_LAT, 1, cycles from RD assertion to valid DataIn (supported values: 1 or 2)

Ports:
- Clk1  in  1  sole clock; all logic on posedge
- Reset  in  1  asynchronous, active-high reset
- Req  in  2  burst request, one bit per requester; level, held until Done
- ReqWr  in  2  per-requester direction: 1 = write burst, 0 = read burst
- ReqAddr0, ReqAddr1  in  ADDR_W each  burst base address
- ReqLen0, ReqLen1  in  LEN_W each  burst length
- WData0, WData1  in  DATA_W each  current write word
- Gnt  out  2  one-hot grant, held for the whole burst
- WAck  out  2  pulse: current write word consumed; requester presents the next word the following cycle
- RValid  out  2  pulse: RData carries a read word for this requester
- RData  out  DATA_W  read data, shared by both requesters
- Done  out  2  one-cycle pulse after the last word completes
- Addr  out  ADDR_W  memory address
- RD  out  1  memory read strobe
- WR  out  1  memory write strobe
- DataOut  out  DATA_W  memory write data
- DataIn  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, any state):
  - Gnt, WAck, RValid, Done, RD, WR all = 0.
  - Addr, DataOut, RData = 0.
  - Priority pointer = requester 0; state = IDLE.
  - An in-flight burst is abandoned, with no Done.
- States:
  - IDLE: if Req != 0, select the winner, latch its address, length and direction, set Gnt, go to XFER. Otherwise stay in IDLE.
  - XFER: issue one word per cycle.
  - DRAIN: wait for outstanding read data (RD_LAT cycles).
  - FIN: pulse Done, clear Gnt, toggle the priority pointer, return to IDLE.
- Arbitration:
  - If only one Req bit is set, that requester wins.
  - If both are set, the requester indicated by the pointer wins.
  - After every completed burst the pointer moves to the other requester, so back-to-back simultaneous requests alternate 0,1,0,1.
  - The grant decision takes one cycle. Gnt rises the cycle after entering IDLE with a request.
- XFER, per word k (k = 0..N-1):
  - Addr = base + k, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - Write burst: WR = 1, DataOut = WData of the granted requester, WAck pulses in the same cycle.
  - Read burst: RD = 1; RData = DataIn and RValid pulses exactly RD_LAT cycles later.
- Exit from XFER:
  - After word N-1 the next state is DRAIN for reads, or FIN directly for writes.
  - RD/WR drop to 0 on leaving XFER.
- Latency:
  - Write burst of N words: Gnt to Done = N+1 cycles.
  - Read burst of N words: Gnt to Done = N+RD_LAT+1 cycles.
  - At least one IDLE cycle separates consecutive bursts.
- Boundary conditions:
  - Req deasserted mid-burst is ignored; the burst completes and Done still pulses.
  - A Req bit set during a burst is served at the next IDLE.
  - A length of 0 runs 16 words.
  - Req, ReqWr, ReqAddr and ReqLen are sampled only in IDLE; later changes have no effect on the current burst.
  - Gnt is never two-hot. RD and WR are never asserted together.
  - RValid/WAck assert only for the granted requester.

Decomposition:
- Shared package (cvp14_pkg):
  - State encodings IDLE/XFER/DRAIN/FIN.
  - Requester index constants REQ_CORE = 0, REQ_DMA = 1.
  - Default widths.
- One sub-module, rr_arb2: a two-input round-robin selector.
  - Inputs: Req[1:0], pointer.
  - Output: one-hot winner.
  - Pointer update on an advance strobe.
- The address counter, word counter and read-latency shift register live in the top module.

Test Plan:
- Reset, then Req = 01, read, base 0x0100, len 4, DataIn = address echo -> Addr 0x0100..0x0103 with RD = 1; RValid0 x4 with RData 0x0100..0x0103; Done0 pulses at cycle Gnt+6 (RD_LAT = 1).
- Req = 11 simultaneously, both write len 2 -> core burst first, Gnt never 2'b11, then DMA burst. Repeat with Req = 11 -> core again; order is 0,1,0,1.
- Write, base 0xFFFE, len 3 -> Addr 0xFFFE, 0xFFFF, 0x0000; three WAck pulses; DataOut follows WData per word.
- Len 0 read -> exactly 16 RD cycles and 16 RValid pulses.
- Req0 dropped after word 2 of a len-8 burst -> all 8 words complete and Done0 pulses.
- Reset asserted mid-burst (word 5 of 16) -> RD/WR/Gnt go to 0 with no clock edge; after release the block is in IDLE with the pointer at 0 and Done never pulsed.
